// File: rtl/timer_bank_pkg.sv
// Shared definitions for the timer bank: register map, CTRL bit layout and
// the per-channel write-strobe bundle.
package timer_bank_pkg;

  localparam logic [1:0] REG_RELOAD = 2'd0;
  localparam logic [1:0] REG_COUNT  = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_IE        = 1;
  localparam int CTRL_OS        = 2;
  localparam int CTRL_PRESC_LSB = 8;

  typedef struct packed {
    logic reload;
    logic count;
    logic ctrl;
    logic status;
  } reg_we_t;

endpackage

// File: rtl/timer_bank_if.sv
// CPU data-bus view of the timer bank: select, address, strobes and
// registered read data.
interface timer_bank_if;
  logic        sel;
  logic [31:0] Address;
  logic [31:0] Write_data;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Read_data;

  modport master (
    output sel, Address, Write_data, MemRead, MemWrite,
    input  Read_data
  );

  modport slave (
    input  sel, Address, Write_data, MemRead, MemWrite,
    output Read_data
  );
endinterface

// File: rtl/timer_bank_channel.sv
// One timer channel: reload/count registers, prescaler, one-shot/periodic
// control and a write-1-to-clear pending flag driving the channel irq.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  reg_we_t     we,
  input  logic [31:0] wdata,
  output logic [31:0] reload_rd,
  output logic [31:0] count_rd,
  output logic [31:0] ctrl_rd,
  output logic [31:0] status_rd,
  output logic        irq
);

  logic [CNT_W-1:0]   reload_q, reload_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] pc_q, pc_d;
  logic               en_q, en_d;
  logic               ie_q, ie_d;
  logic               os_q, os_d;
  logic               pending_q, pending_d;

  logic tick;
  logic count_tick;
  logic expire;
  logic unused_wdata;

  assign unused_wdata = ^wdata;

  // A CPU write to COUNT swallows the tick entirely, so no expiry either.
  assign tick       = en_q && (pc_q == presc_q);
  assign count_tick = tick && !we.count;
  assign expire     = count_tick && (count_q == {CNT_W{1'b1}});

  always_comb begin
    reload_d  = reload_q;
    count_d   = count_q;
    presc_d   = presc_q;
    en_d      = en_q;
    ie_d      = ie_q;
    os_d      = os_q;
    pending_d = pending_q;
    pc_d      = (en_q && !tick) ? pc_q + 1'b1 : '0;

    if (count_tick) begin
      count_d = expire ? reload_q : count_q + 1'b1;
    end
    if (expire) begin
      pending_d = 1'b1;
      if (os_q) begin
        en_d = 1'b0;
      end
    end

    if (we.reload) begin
      reload_d = wdata[CNT_W-1:0];
    end
    if (we.count) begin
      count_d = wdata[CNT_W-1:0];
    end
    if (we.ctrl) begin
      en_d    = wdata[CTRL_EN];
      ie_d    = wdata[CTRL_IE];
      os_d    = wdata[CTRL_OS];
      presc_d = wdata[CTRL_PRESC_LSB +: PRESC_W];
      pc_d    = '0;
    end
    // A simultaneous expiry beats the clear so the event is never lost.
    if (we.status && wdata[0] && !expire) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reload_q  <= '0;
      count_q   <= '0;
      presc_q   <= '0;
      pc_q      <= '0;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      os_q      <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      reload_q  <= reload_d;
      count_q   <= count_d;
      presc_q   <= presc_d;
      pc_q      <= pc_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      os_q      <= os_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    reload_rd                                  = '0;
    reload_rd[CNT_W-1:0]                       = reload_q;
    count_rd                                   = '0;
    count_rd[CNT_W-1:0]                        = count_q;
    ctrl_rd                                    = '0;
    ctrl_rd[CTRL_EN]                           = en_q;
    ctrl_rd[CTRL_IE]                           = ie_q;
    ctrl_rd[CTRL_OS]                           = os_q;
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_W]         = presc_q;
    status_rd                                  = '0;
    status_rd[0]                               = pending_q;
  end

  assign irq = pending_q & ie_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of independent timers on the CPU data bus: address decode, per-channel
// write strobes, registered read mux and interrupt aggregation.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NUM_TIMERS = 4,
  parameter int CH_BITS    = 2,
  parameter int CNT_W      = 32,
  parameter int PRESC_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  timer_bank_if.slave           bus,
  output logic [NUM_TIMERS-1:0] irq,
  output logic                  irq_any
);

  logic [1:0]         reg_sel;
  logic [CH_BITS-1:0] ch_sel;
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        ch_rd [NUM_TIMERS];
  logic [31:0]        read_data_d, read_data_q;
  logic               unused_addr;

  assign reg_sel     = bus.Address[3:2];
  assign ch_sel      = bus.Address[CH_BITS+3:4];
  assign wr_en       = bus.sel && bus.MemWrite;
  assign rd_en       = bus.sel && bus.MemRead;
  assign unused_addr = ^bus.Address;

  for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_ch
    logic        hit;
    reg_we_t     we;
    logic [31:0] reload_rd, count_rd, ctrl_rd, status_rd;

    assign hit       = wr_en && (ch_sel == CH_BITS'(gi));
    assign we.reload = hit && (reg_sel == REG_RELOAD);
    assign we.count  = hit && (reg_sel == REG_COUNT);
    assign we.ctrl   = hit && (reg_sel == REG_CTRL);
    assign we.status = hit && (reg_sel == REG_STATUS);

    timer_channel #(
      .CNT_W   (CNT_W),
      .PRESC_W (PRESC_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .wdata     (bus.Write_data),
      .reload_rd (reload_rd),
      .count_rd  (count_rd),
      .ctrl_rd   (ctrl_rd),
      .status_rd (status_rd),
      .irq       (irq[gi])
    );

    assign ch_rd[gi] = (reg_sel == REG_RELOAD) ? reload_rd :
                       (reg_sel == REG_COUNT)  ? count_rd  :
                       (reg_sel == REG_CTRL)   ? ctrl_rd   : status_rd;
  end

  // Unpopulated channel indices match nothing and therefore read as zero.
  always_comb begin
    read_data_d = '0;
    if (rd_en) begin
      for (int i = 0; i < NUM_TIMERS; i++) begin
        if (ch_sel == CH_BITS'(i)) begin
          read_data_d = ch_rd[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= read_data_d;
    end
  end

  assign bus.Read_data = read_data_q;
  assign irq_any       = |irq;

endmodule
